// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and hazard/stall control for the 5-stage pipeline (load-use, mul/div occupancy).
// Optional macro STALL_CNT_EN adds the stall_cnt / ld_stall_cnt performance counters.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int MD_LAT     = 4,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_alu_src,
    input  logic                  id_is_muldiv,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic                  branch_flush,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic [1:0]            fa,
    output logic [1:0]            fb,
    output logic                  md_busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [15:0]           ld_stall_cnt
`endif
);

    localparam int CNT_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_MD_BUSY  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic       rs_zero_s;
    logic       rt_zero_s;
    logic       hit_a_ex_s;
    logic       hit_b_ex_s;
    logic       hit_a_mem_s;
    logic       hit_b_mem_s;
    logic       load_use_s;
    logic       issue_s;
    logic [1:0] fa_sel_s;
    logic [1:0] fb_sel_s;
    logic       stall_s;
    logic       bubble_s;
    logic       busy_s;
    logic       ld_event_s;
    logic [1:0] fa_r;
    logic [1:0] fb_r;

    // Source/destination matches in ID; operand B never forwards when it is an immediate.
    always_comb begin
        rs_zero_s   = (ZERO_REG != 0) && (id_rs == {REG_ADDR_W{1'b0}});
        rt_zero_s   = (ZERO_REG != 0) && (id_rt == {REG_ADDR_W{1'b0}});
        hit_a_ex_s  = id_valid & id_use_rs & ex_regwrite & (ex_rd == id_rs) & ~rs_zero_s;
        hit_b_ex_s  = id_valid & id_use_rt & ~id_alu_src & ex_regwrite & (ex_rd == id_rt) & ~rt_zero_s;
        hit_a_mem_s = id_valid & id_use_rs & mem_regwrite & (mem_rd == id_rs) & ~rs_zero_s;
        hit_b_mem_s = id_valid & id_use_rt & ~id_alu_src & mem_regwrite & (mem_rd == id_rt) & ~rt_zero_s;
        load_use_s  = id_valid & ex_memread & (hit_a_ex_s | hit_b_ex_s);
        issue_s     = id_valid & id_is_muldiv;
    end

    // Forward select: the younger producer (now in EX, next in EX/MEM) wins over MEM/WB.
    always_comb begin
        if (hit_a_ex_s) begin
            fa_sel_s = FWD_EXMEM;
        end else if (hit_a_mem_s) begin
            fa_sel_s = FWD_MEMWB;
        end else begin
            fa_sel_s = FWD_RF;
        end
        if (hit_b_ex_s) begin
            fb_sel_s = FWD_EXMEM;
        end else if (hit_b_mem_s) begin
            fb_sel_s = FWD_MEMWB;
        end else begin
            fb_sel_s = FWD_RF;
        end
    end

    // Hazard FSM next-state and stall decode; LD_STALL decides like IDLE since EX now holds a bubble.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        busy_s      = 1'b0;
        ld_event_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_LD_STALL: begin
                if (branch_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (load_use_s) begin
                    stall_s     = 1'b1;
                    ld_event_s  = 1'b1;
                    state_nxt_s = ST_LD_STALL;
                end else if (issue_s) begin
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = ST_MD_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MD_BUSY: begin
                busy_s = 1'b1;
                if (cnt_r != CNT_ZERO) begin
                    // A flush here does not abort the count: the mul/div is already in EX.
                    stall_s   = 1'b1;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else if (branch_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (load_use_s) begin
                    stall_s     = 1'b1;
                    ld_event_s  = 1'b1;
                    state_nxt_s = ST_LD_STALL;
                end else if (issue_s) begin
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = ST_MD_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
        bubble_s = stall_s | branch_flush;
    end

    // FSM state and mul/div countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Forward selects registered into EX; a bubble or killed instruction carries no forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fa_r <= FWD_RF;
            fb_r <= FWD_RF;
        end else if (bubble_s) begin
            fa_r <= FWD_RF;
            fb_r <= FWD_RF;
        end else begin
            fa_r <= fa_sel_s;
            fb_r <= fb_sel_s;
        end
    end

    // Stall outputs are decoded combinationally; gating with rst_n drops them the instant reset asserts.
    always_comb begin
        pc_stall    = rst_n & stall_s;
        ifid_stall  = rst_n & stall_s;
        idex_bubble = rst_n & bubble_s;
        md_busy     = rst_n & busy_s;
        fa          = fa_r;
        fb          = fb_r;
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [15:0] ld_stall_cnt_r;

    // Stall-cycle counter wraps; load-use event counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r    <= 32'd0;
            ld_stall_cnt_r <= 16'd0;
        end else begin
            if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (ld_event_s && (ld_stall_cnt_r != 16'hFFFF)) begin
                ld_stall_cnt_r <= ld_stall_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cnt    = stall_cnt_r;
    assign ld_stall_cnt = ld_stall_cnt_r;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: reference model, fa/fb scoreboard queue, directed + random vectors.
module tb_fwd_hazard_unit;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_alu_src, id_is_muldiv;
    logic [3:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, branch_flush;
    logic       pc_stall, ifid_stall, idex_bubble, md_busy;
    logic [1:0] fa, fb;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [15:0] ld_stall_cnt;
    int unsigned m_stall_cnt;
    int unsigned m_ld_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    bit m_busy;
    int m_cnt;

    fwd_hazard_unit #(.REG_ADDR_W(4), .MD_LAT(MD_LAT), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_alu_src(id_alu_src),
        .id_is_muldiv(id_is_muldiv), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .branch_flush(branch_flush), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .fa(fa), .fb(fb), .md_busy(md_busy)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt), .ld_stall_cnt(ld_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hit(input logic vld, input logic use_r, input logic [3:0] src,
                               input logic wr, input logic [3:0] dst);
        return vld && use_r && wr && (src == dst) && (src != 4'd0);
    endfunction

    function automatic logic [1:0] sel(input bit h_ex, input bit h_mem);
        if (h_ex) return 2'b01;
        if (h_mem) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
`ifdef STALL_CNT_EN
        m_stall_cnt = 0;
        m_ld_cnt    = 0;
`endif
    endtask

    // One pipeline cycle: check combinational outputs, queue the fa/fb due after the edge, then compare it.
    task automatic cycle();
        bit ha_ex, hb_ex, ha_mem, hb_mem, lu, md_run, e_stall, e_bub;
        logic [3:0] got;
        #1;
        ha_ex  = hit(id_valid, id_use_rs, id_rs, ex_regwrite, ex_rd);
        hb_ex  = hit(id_valid, id_use_rt && !id_alu_src, id_rt, ex_regwrite, ex_rd);
        ha_mem = hit(id_valid, id_use_rs, id_rs, mem_regwrite, mem_rd);
        hb_mem = hit(id_valid, id_use_rt && !id_alu_src, id_rt, mem_regwrite, mem_rd);
        lu     = ex_memread && (ha_ex || hb_ex);
        md_run = m_busy && (m_cnt > 0);
        e_stall = md_run || (!branch_flush && lu);
        e_bub   = e_stall || branch_flush;
        chk("pc_stall", {31'd0, pc_stall}, {31'd0, e_stall});
        chk("ifid_stall", {31'd0, ifid_stall}, {31'd0, e_stall});
        chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e_bub});
        chk("md_busy", {31'd0, md_busy}, {31'd0, m_busy});
        exp_q.push_back(e_bub ? 4'b0000 : {sel(ha_ex, ha_mem), sel(hb_ex, hb_mem)});
`ifdef STALL_CNT_EN
        if (e_stall) m_stall_cnt++;
        if (!md_run && !branch_flush && lu && m_ld_cnt != 32'hFFFF) m_ld_cnt++;
`endif
        if (md_run) m_cnt--;
        else if (branch_flush || lu) m_busy = 1'b0;
        else if (id_valid && id_is_muldiv) begin m_busy = 1'b1; m_cnt = MD_LAT - 1; end
        else m_busy = 1'b0;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            chk("fa", {30'd0, fa}, {30'd0, got[3:2]});
            chk("fb", {30'd0, fb}, {30'd0, got[1:0]});
        end
`ifdef STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("ld_stall_cnt", {16'd0, ld_stall_cnt}, m_ld_cnt);
`endif
    endtask

    task automatic apply(input logic vld, input logic [3:0] rs, input logic [3:0] rt,
                         input logic urs, input logic urt, input logic alu, input logic md,
                         input logic [3:0] erd, input logic ew, input logic emr,
                         input logic [3:0] mrd, input logic mw, input logic fl);
        id_valid = vld; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_alu_src = alu; id_is_muldiv = md; ex_rd = erd; ex_regwrite = ew;
        ex_memread = emr; mem_rd = mrd; mem_regwrite = mw; branch_flush = fl;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pc_stall"}, {31'd0, pc_stall}, 32'd0);
        chk({tag, "_ifid_stall"}, {31'd0, ifid_stall}, 32'd0);
        chk({tag, "_idex_bubble"}, {31'd0, idex_bubble}, 32'd0);
        chk({tag, "_md_busy"}, {31'd0, md_busy}, 32'd0);
        chk({tag, "_fa"}, {30'd0, fa}, 32'd0);
        chk({tag, "_fb"}, {30'd0, fb}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs = 4'd0; id_rt = 4'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_alu_src = 1'b0; id_is_muldiv = 1'b0; ex_rd = 4'd0; ex_regwrite = 1'b0;
        ex_memread = 1'b0; mem_rd = 4'd0; mem_regwrite = 1'b0; branch_flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #4 rst_n = 1'b1;
        idle(1);

        // EX/MEM priority over MEM/WB, then MEM/WB only (rt hits EX)
        apply(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        apply(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        // Load-use on rt, then the stalled instruction sees the load in MEM/WB
        apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        // Same load with an immediate operand B: no stall
        apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        // Register 0 is never a hazard
        apply(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        // id_valid=0 with matching registers
        apply(1'b0, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0);
        // Mul/div issue then occupancy, flush in second busy cycle
        apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
        apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
        apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Back-to-back mul/div: second one waits in ID and issues as the count expires
        for (int i = 0; i < 5; i++)
            apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Load-use coincident with branch flush
        apply(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
        idle(1);
        // Load-use together with mul/div: stall first, issue from LD_STALL
        apply(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        apply(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        apply(1'b1, 4'd5, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Asynchronous reset in the middle of the mul/div stall
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        #2 rst_n = 1'b1;
        apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            apply(1'b1, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Random traffic over a small register range to provoke overlaps
        for (int i = 0; i < 300; i++)
            apply(($urandom_range(0, 7) != 0), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  4'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 9) == 0));
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
